// File: rtl/rram_instr_arbiter.sv
// Two-source arbiter in front of one crossbar controller. A grant covers one
// instruction from the moment it is offered until the controller retires it,
// so the data beats of the ext and hd sources never interleave.
module rram_instr_arbiter #(
    parameter int unsigned INSTR_WIDTH    = 4,
    parameter int unsigned OPCODE_WIDTH   = 16,
    parameter int unsigned DATAIN_WIDTH   = 64,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned HD_PRIORITY    = 0
) (
    input  logic                                CLK,
    input  logic                                reset_n,
    // ext source FIFO set
    output logic                                pop_n_instFIFO_ext,
    input  logic                                empty_instFIFO_ext,
    input  logic [INSTR_WIDTH+OPCODE_WIDTH-1:0] dout_instFIFO_ext,
    output logic                                pop_n_iFIFO_ext,
    input  logic                                empty_iFIFO_ext,
    input  logic [DATAIN_WIDTH-1:0]             dout_iFIFO_ext,
    output logic                                push_n_oFIFO_ext,
    input  logic                                full_oFIFO_ext,
    output logic [DATAIN_WIDTH-1:0]             din_oFIFO_ext,
    // hd source FIFO set
    output logic                                pop_n_instFIFO_hd,
    input  logic                                empty_instFIFO_hd,
    input  logic [INSTR_WIDTH+OPCODE_WIDTH-1:0] dout_instFIFO_hd,
    output logic                                pop_n_iFIFO_hd,
    input  logic                                empty_iFIFO_hd,
    input  logic [DATAIN_WIDTH-1:0]             dout_iFIFO_hd,
    output logic                                push_n_oFIFO_hd,
    input  logic                                full_oFIFO_hd,
    output logic [DATAIN_WIDTH-1:0]             din_oFIFO_hd,
    // merged FIFO set seen by the controller
    input  logic                                pop_n_instFIFO,
    output logic                                empty_instFIFO,
    output logic [INSTR_WIDTH+OPCODE_WIDTH-1:0] dout_instFIFO,
    input  logic                                pop_n_iFIFO,
    output logic                                empty_iFIFO,
    output logic [DATAIN_WIDTH-1:0]             dout_iFIFO,
    input  logic                                push_n_oFIFO,
    output logic                                full_oFIFO,
    input  logic [DATAIN_WIDTH-1:0]             din_oFIFO,
    // status
    input  logic                                instr_done,
    output logic                                grant_hd,
    output logic                                busy,
    output logic                                timeout_err
);

    localparam int unsigned IW = INSTR_WIDTH + OPCODE_WIDTH;
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOCK = 2'd1,
        S_BUSY = 2'd2
    } state_t;

    state_t        state;
    logic          last_hd;
    logic [CW-1:0] cnt;

    logic req_ext;
    logic req_hd;
    logic pick_hd;
    logic sel_empty_inst;

    assign req_ext = ~empty_instFIFO_ext;
    assign req_hd  = ~empty_instFIFO_hd;
    // hd wins when it is alone, when it has tie priority, or when ext was served last
    assign pick_hd = req_hd & (~req_ext | (HD_PRIORITY != 0) | ~last_hd);
    assign sel_empty_inst = grant_hd ? empty_instFIFO_hd : empty_instFIFO_ext;

    // Grant FSM with watchdog counter and sticky timeout flag
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            grant_hd    <= 1'b0;
            last_hd     <= 1'b1;
            cnt         <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (req_ext | req_hd) begin
                        grant_hd <= pick_hd;
                        state    <= S_LOCK;
                    end
                end
                S_LOCK: begin
                    if (!pop_n_instFIFO) begin
                        state <= S_BUSY;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end else if (sel_empty_inst) begin
                        state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + CW'(1);
                    end
                    if (instr_done) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        last_hd <= grant_hd;
                    end else if (cnt == CNT_LAST) begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        last_hd     <= grant_hd;
                        timeout_err <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Route the granted source to the controller; idle and non-granted sides stay quiet
    always_comb begin
        pop_n_instFIFO_ext = 1'b1;
        pop_n_iFIFO_ext    = 1'b1;
        push_n_oFIFO_ext   = 1'b1;
        din_oFIFO_ext      = '0;
        pop_n_instFIFO_hd  = 1'b1;
        pop_n_iFIFO_hd     = 1'b1;
        push_n_oFIFO_hd    = 1'b1;
        din_oFIFO_hd       = '0;
        empty_instFIFO     = 1'b1;
        dout_instFIFO      = IW'(0);
        empty_iFIFO        = 1'b1;
        dout_iFIFO         = '0;
        full_oFIFO         = 1'b1;
        if (state != S_IDLE) begin
            if (grant_hd) begin
                empty_instFIFO    = (state == S_BUSY) | empty_instFIFO_hd;
                dout_instFIFO     = dout_instFIFO_hd;
                empty_iFIFO       = empty_iFIFO_hd;
                dout_iFIFO        = dout_iFIFO_hd;
                full_oFIFO        = full_oFIFO_hd;
                pop_n_instFIFO_hd = (state == S_BUSY) | pop_n_instFIFO;
                pop_n_iFIFO_hd    = pop_n_iFIFO;
                push_n_oFIFO_hd   = push_n_oFIFO;
                din_oFIFO_hd      = din_oFIFO;
            end else begin
                empty_instFIFO     = (state == S_BUSY) | empty_instFIFO_ext;
                dout_instFIFO      = dout_instFIFO_ext;
                empty_iFIFO        = empty_iFIFO_ext;
                dout_iFIFO         = dout_iFIFO_ext;
                full_oFIFO         = full_oFIFO_ext;
                pop_n_instFIFO_ext = (state == S_BUSY) | pop_n_instFIFO;
                pop_n_iFIFO_ext    = pop_n_iFIFO;
                push_n_oFIFO_ext   = push_n_oFIFO;
                din_oFIFO_ext      = din_oFIFO;
            end
        end
    end

endmodule
